mcu_dispatch: RTL and testbench
===============================

MCU_DISPATCH -- requirements
Module: mcu_dispatch

Interface
REQ-001 Parameter TIMEOUT_CYC, default 32'd2_000_000, frame-abort timeout in clk cycles.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in_strobe  input  1  one-cycle pulse: MCU byte valid.
REQ-005 data_in_start  input  1  qualifies strobe: first byte of a frame.
REQ-006 data_in  input  8  MCU byte.
REQ-007 data_out  output  8  reply byte to MCU, registered.
REQ-008 tgt_strobe  output  4  one-hot forwarded strobe; bit n = target n.
REQ-009 tgt_start  output  1  forwarded start flag; valid with tgt_strobe.
REQ-010 tgt_data  output  8  forwarded byte; valid with tgt_strobe.
REQ-011 tgt_dout  input  32  target reply bytes; target n on bits [8n+7:8n].
REQ-012 tgt_irq  input  4  active-high interrupt request per target.
REQ-013 int_out_n  output  1  active-low interrupt to MCU, registered.
REQ-014 err_cnt  output  8  saturating protocol error counter.

Function
REQ-015 Targets: id 0 sysctrl, 1 hid, 2 osd, 3 sdc; id >= 4 invalid.
REQ-016 FSM states IDLE, HDR, PAYLOAD; 2-bit encoding.
REQ-017 Strobe with start, any state: sel <= data_in, state <= HDR, data_out <= 8'h00, timeout reloaded; an in-progress frame is abandoned without error.
REQ-018 HDR, strobe without start: valid sel -> forward byte with tgt_start=1; invalid sel -> no forward, err_cnt +1; state <= PAYLOAD in both cases.
REQ-019 PAYLOAD, strobe without start: valid sel -> forward byte with tgt_start=0; invalid sel -> byte dropped, no error.
REQ-020 IDLE, strobe without start: byte dropped, err_cnt +1, data_out unchanged.
REQ-021 Forwarding: tgt_strobe[sel], tgt_start and tgt_data registered, asserted exactly one cycle after the MCU strobe, tgt_strobe high for exactly one cycle; all tgt_strobe bits 0 otherwise.
REQ-022 Never more than one tgt_strobe bit high in any cycle.
REQ-023 tgt_data and tgt_start hold their last values when tgt_strobe is 0.
REQ-024 In HDR or PAYLOAD with valid sel, data_out <= tgt_dout[sel] every cycle; latency from MCU strobe to reply in data_out is 3 cycles (forward, target, capture).
REQ-025 With invalid sel or in IDLE, data_out holds its value, except REQ-017 clear.
REQ-026 Timeout counter reloads to TIMEOUT_CYC on every strobe; decrements in HDR/PAYLOAD; on reaching 0: state <= IDLE, err_cnt +1.
REQ-027 Timeout counter is frozen in IDLE.
REQ-028 err_cnt saturates at 8'hFF; simultaneous error sources in one cycle increment by 1 only.
REQ-029 A strobe in the same cycle as timeout expiry takes priority; the timeout is ignored.
REQ-030 int_out_n <= ~(|tgt_irq), one cycle latency, independent of FSM state.

Reset
REQ-031 Reset yields: state IDLE, sel 3'd0, data_out 8'h00, tgt_strobe 4'b0000, tgt_start 0, tgt_data 8'h00, int_out_n 1, err_cnt 8'h00, timeout counter 0.
REQ-032 Reset mid-frame drops the frame; no forwarded strobe is emitted in the cycle after reset deasserts.

Structure
REQ-033 Shared package mcu_pkg holds target id constants (TGT_SYS, TGT_HID, TGT_OSD, TGT_SDC), NUM_TGT=4 and the FSM state encoding.
REQ-034 Single module; no sub-module. The 8-bit saturating increment is inline logic.

Verification
REQ-035 Frame {start 8'h00, 8'h00, 8'h11, 8'h22} with tgt_dout[7:0] = 8'h5C -> tgt_strobe 4'b0001 three times, tgt_start=1 only with byte 8'h00, data_out=8'h5C 3 cycles after the second strobe, err_cnt=0.
REQ-036 Frame {start 8'h03, 8'h08, 8'hAA} -> only tgt_strobe[3] pulses, data 8'h08 then 8'hAA; no other bit ever high.
REQ-037 Frame {start 8'h07, 8'h01, 8'h02} -> no tgt_strobe, data_out stays 8'h00, err_cnt=1.
REQ-038 Start 8'h01 then a new start 8'h02 before payload; or TIMEOUT_CYC=16 with no strobe for 16 cycles after a start -> new frame routes to target 2 with no error; timeout returns FSM to IDLE with err_cnt=1; a following non-start byte adds 1 more.
REQ-039 tgt_irq=4'b0100 -> int_out_n=0 after 1 cycle; tgt_irq=0 -> int_out_n=1 after 1 cycle; 300 IDLE non-start strobes -> err_cnt saturates at 8'hFF.
REQ-040 Reset asserted during PAYLOAD of a target 1 frame -> all outputs at REQ-031 values; next non-start byte counts as IDLE error.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU byte dispatcher: target ids, target count, FSM encoding.
// Pure declarations; no timing or flow-control behaviour.
package mcu_pkg;

  localparam int NUM_TGT = 4;

  localparam logic [2:0] TGT_SYS = 3'd0;
  localparam logic [2:0] TGT_HID = 3'd1;
  localparam logic [2:0] TGT_OSD = 3'd2;
  localparam logic [2:0] TGT_SDC = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

endpackage

// File: rtl/mcu_dispatch_if.sv
// MCU-side byte bus plus the fan-out bus to the targets, bundled for the dispatcher.
// master = MCU/target environment, slave = dispatcher; strobe-qualified, no backpressure.
interface mcu_dispatch_if;
  import mcu_pkg::*;

  logic                   data_in_strobe;
  logic                   data_in_start;
  logic [7:0]             data_in;
  logic [7:0]             data_out;
  logic [NUM_TGT-1:0]     tgt_strobe;
  logic                   tgt_start;
  logic [7:0]             tgt_data;
  logic [8*NUM_TGT-1:0]   tgt_dout;
  logic [NUM_TGT-1:0]     tgt_irq;
  logic                   int_out_n;
  logic [7:0]             err_cnt;

  modport master (
    output data_in_strobe, data_in_start, data_in, tgt_dout, tgt_irq,
    input  data_out, tgt_strobe, tgt_start, tgt_data, int_out_n, err_cnt
  );

  modport slave (
    input  data_in_strobe, data_in_start, data_in, tgt_dout, tgt_irq,
    output data_out, tgt_strobe, tgt_start, tgt_data, int_out_n, err_cnt
  );

endinterface

// File: rtl/mcu_dispatch.sv
// Routes MCU byte frames to one of four targets by header id; forward is 1 cycle, reply 3 cycles.
// No backpressure: every strobe is consumed; idle frames abort after TIMEOUT_CYC cycles.
module mcu_dispatch
  import mcu_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000
) (
  input  logic         clk,
  input  logic         reset,
  mcu_dispatch_if.slave bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [2:0]         r_sel;
  logic               r_sel_ovf;
  logic [31:0]        r_tmo;
  logic [7:0]         r_data_out;
  logic [NUM_TGT-1:0] r_tgt_strobe;
  logic               r_tgt_start;
  logic [7:0]         r_tgt_data;
  logic               r_int_n;
  logic [7:0]         r_err;

  logic               w_start_stb;
  logic               w_data_stb;
  logic               w_sel_vld;
  logic               w_in_frame;
  logic               w_fwd;
  logic               w_fwd_start;
  logic               w_err;
  logic               w_expire;
  logic [7:0]         w_reply;

  assign w_start_stb = bus.data_in_strobe & bus.data_in_start;
  assign w_data_stb  = bus.data_in_strobe & ~bus.data_in_start;
  // Header bytes above 7 are remembered as overflow so they never alias a valid id.
  assign w_sel_vld   = ~r_sel_ovf & (r_sel <= TGT_SDC);
  assign w_in_frame  = (r_state == ST_HDR) | (r_state == ST_PAYLOAD);
  assign w_reply     = bus.tgt_dout[{r_sel[1:0], 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A strobe always wins over timeout expiry in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_fwd_start = 1'b0;
    w_err       = 1'b0;
    w_expire    = 1'b0;
    if (w_start_stb) begin
      w_state_nxt = ST_HDR;
    end else if (w_data_stb) begin
      case (r_state)
        ST_IDLE: w_err = 1'b1;
        ST_HDR: begin
          w_state_nxt = ST_PAYLOAD;
          w_fwd       = w_sel_vld;
          w_fwd_start = w_sel_vld;
          w_err       = ~w_sel_vld;
        end
        ST_PAYLOAD: w_fwd = w_sel_vld;
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (w_in_frame && r_tmo <= 32'd1) begin
      w_expire    = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= 3'd0;
      r_sel_ovf    <= 1'b0;
      r_tmo        <= 32'd0;
      r_data_out   <= 8'h00;
      r_tgt_strobe <= '0;
      r_tgt_start  <= 1'b0;
      r_tgt_data   <= 8'h00;
      r_int_n      <= 1'b1;
      r_err        <= 8'h00;
    end else begin
      r_tgt_strobe <= w_fwd ? (NUM_TGT'(1) << r_sel[1:0]) : '0;
      if (w_fwd) begin
        r_tgt_start <= w_fwd_start;
        r_tgt_data  <= bus.data_in;
      end
      if (w_start_stb) begin
        r_sel      <= bus.data_in[2:0];
        r_sel_ovf  <= |bus.data_in[7:3];
        r_data_out <= 8'h00;
      end else if (w_in_frame && w_sel_vld) begin
        r_data_out <= w_reply;
      end
      if (bus.data_in_strobe) begin
        r_tmo <= TIMEOUT_CYC;
      end else if (w_expire) begin
        r_tmo <= 32'd0;
      end else if (w_in_frame) begin
        r_tmo <= r_tmo - 32'd1;
      end
      if ((w_err | w_expire) && r_err != 8'hFF) begin
        r_err <= r_err + 8'd1;
      end
      r_int_n <= ~(|bus.tgt_irq);
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.tgt_strobe = r_tgt_strobe;
  assign bus.tgt_start  = r_tgt_start;
  assign bus.tgt_data   = r_tgt_data;
  assign bus.int_out_n  = r_int_n;
  assign bus.err_cnt    = r_err;

endmodule

// File: tb/tb_mcu_dispatch.sv
// Directed bench for mcu_dispatch: a per-cycle vector table plus hand-written corner sequences.
module tb_mcu_dispatch;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_tot;

  mcu_dispatch_if bus();

  mcu_dispatch #(.TIMEOUT_CYC(32'd16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       stb;
    logic       st;
    logic [7:0] din;
    logic [3:0] irq;
    logic [3:0] e_stb;
    logic       e_st;
    logic [7:0] e_td;
    logic [7:0] e_do;
    logic       e_intn;
    logic [7:0] e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic stb, input logic st,
                              input logic [7:0] din, input logic [3:0] irq,
                              input logic [3:0] e_stb, input logic e_st,
                              input logic [7:0] e_td, input logic [7:0] e_do,
                              input logic e_intn, input logic [7:0] e_err);
    vec_t v;
    v.rst = rst; v.stb = stb; v.st = st; v.din = din; v.irq = irq;
    v.e_stb = e_stb; v.e_st = e_st; v.e_td = e_td; v.e_do = e_do;
    v.e_intn = e_intn; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_stb, input logic e_st,
                           input logic [7:0] e_td, input logic [7:0] e_do,
                           input logic e_intn, input logic [7:0] e_err);
    chk({tag, " tgt_strobe"}, 32'(bus.tgt_strobe), 32'(e_stb));
    chk({tag, " tgt_start"},  32'(bus.tgt_start),  32'(e_st));
    chk({tag, " tgt_data"},   32'(bus.tgt_data),   32'(e_td));
    chk({tag, " data_out"},   32'(bus.data_out),   32'(e_do));
    chk({tag, " int_out_n"},  32'(bus.int_out_n),  32'(e_intn));
    chk({tag, " err_cnt"},    32'(bus.err_cnt),    32'(e_err));
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge sample them.
  task automatic step(input logic rst, input logic stb, input logic st, input logic [7:0] din);
    reset              = rst;
    bus.data_in_strobe = stb;
    bus.data_in_start  = st;
    bus.data_in        = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    reset = 1'b1;
    bus.data_in_strobe = 1'b0;
    bus.data_in_start  = 1'b0;
    bus.data_in        = 8'h00;
    bus.tgt_dout       = 32'h4433_225C;
    bus.tgt_irq        = 4'h0;

    //               rst stb st din    irq   | e_stb e_st e_td  e_do  intn err
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'h0,  4'h0, 0, 8'h00, 8'h00, 1, 8'd0));
    tbl.push_back(mk(0, 1, 1, 8'h00, 4'h0,  4'h0, 0, 8'h00, 8'h00, 1, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 4'h0,  4'h1, 1, 8'h00, 8'h5C, 1, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'h11, 4'h0,  4'h1, 0, 8'h11, 8'h5C, 1, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'h22, 4'h0,  4'h1, 0, 8'h22, 8'h5C, 1, 8'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0,  4'h0, 0, 8'h22, 8'h5C, 1, 8'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0,  4'h0, 0, 8'h22, 8'h5C, 1, 8'd0));
    tbl.push_back(mk(0, 1, 1, 8'h03, 4'h0,  4'h0, 0, 8'h22, 8'h00, 1, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'h08, 4'h0,  4'h8, 1, 8'h08, 8'h44, 1, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'hAA, 4'h0,  4'h8, 0, 8'hAA, 8'h44, 1, 8'd0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0,  4'h0, 0, 8'hAA, 8'h44, 1, 8'd0));
    tbl.push_back(mk(0, 1, 1, 8'h07, 4'h0,  4'h0, 0, 8'hAA, 8'h00, 1, 8'd0));
    tbl.push_back(mk(0, 1, 0, 8'h01, 4'h0,  4'h0, 0, 8'hAA, 8'h00, 1, 8'd1));
    tbl.push_back(mk(0, 1, 0, 8'h02, 4'h0,  4'h0, 0, 8'hAA, 8'h00, 1, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0,  4'h0, 0, 8'hAA, 8'h00, 1, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'h4,  4'h0, 0, 8'hAA, 8'h00, 0, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0,  4'h0, 0, 8'hAA, 8'h00, 1, 8'd1));
    // Last strobe was vector 13; the 16th quiet edge after it expires the frame.
    for (int k = 17; k <= 28; k++)
      tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0, 4'h0, 0, 8'hAA, 8'h00, 1, 8'd1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'h0,  4'h0, 0, 8'hAA, 8'h00, 1, 8'd2));
    tbl.push_back(mk(0, 1, 0, 8'h55, 4'h0,  4'h0, 0, 8'hAA, 8'h00, 1, 8'd3));

    for (int i = 0; i < tbl.size(); i++) begin
      bus.tgt_irq = tbl[i].irq;
      step(tbl[i].rst, tbl[i].stb, tbl[i].st, tbl[i].din);
      check_all($sformatf("vec%0d", i), tbl[i].e_stb, tbl[i].e_st, tbl[i].e_td,
                tbl[i].e_do, tbl[i].e_intn, tbl[i].e_err);
    end

    // Restart before payload: second header wins, no error.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    step(1'b0, 1'b1, 1'b1, 8'h02);
    step(1'b0, 1'b1, 1'b0, 8'h10);
    check_all("restart", 4'h4, 1'b1, 8'h10, 8'h33, 1'b1, 8'd0);

    // Strobe arriving on the expiry cycle beats the timeout.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    idle(15);
    chk("pre_expiry err_cnt", 32'(bus.err_cnt), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h77);
    check_all("strobe_at_expiry", 4'h1, 1'b1, 8'h77, 8'h5C, 1'b1, 8'd0);
    idle(15);
    chk("tmo_minus1 err_cnt", 32'(bus.err_cnt), 32'd0);
    idle(1);
    chk("tmo err_cnt", 32'(bus.err_cnt), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h33);
    chk("post_tmo err_cnt", 32'(bus.err_cnt), 32'd2);
    chk("post_tmo tgt_strobe", 32'(bus.tgt_strobe), 32'd0);

    // Saturation from repeated IDLE non-start strobes.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 254; k++) step(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("sat254 err_cnt", 32'(bus.err_cnt), 32'hFE);
    step(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("sat255 err_cnt", 32'(bus.err_cnt), 32'hFF);
    for (int k = 0; k < 45; k++) step(1'b0, 1'b1, 1'b0, 8'h5A);
    chk("sat300 err_cnt", 32'(bus.err_cnt), 32'hFF);

    // Reset in the middle of a target-1 payload.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    bus.tgt_irq = 4'hF;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h05);
    step(1'b0, 1'b1, 1'b0, 8'h06);
    check_all("pre_reset", 4'h2, 1'b0, 8'h06, 8'h22, 1'b0, 8'd1);
    bus.tgt_irq = 4'h0;
    step(1'b1, 1'b1, 1'b0, 8'h07);
    check_all("in_reset", 4'h0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_all("after_reset", 4'h0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'h09);
    check_all("idle_err", 4'h0, 1'b0, 8'h00, 8'h00, 1'b1, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
